ripple_carry_adder_sync: RTL and testbench
==========================================

# ripple_carry_adder_sync

Registered DATA_WIDTH-bit binary adder built from a ripple chain of 1-bit full-adder cells. It produces sum, unsigned carry-out and two's-complement overflow flags. It is the baseline datapath in the adder family, against which the carry-lookahead, carry-select and carry-bypass variants are compared for both function and delay. All three results are captured in output registers on the system clock.

## Interface
- DATA_WIDTH, default 16: operand and sum width in bits; legal range ≥ 2.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- A  input  DATA_WIDTH  addend, unsigned or two's complement.
- B  input  DATA_WIDTH  addend, unsigned or two's complement.
- Cin  input  1  carry into bit 0.
- S  output  DATA_WIDTH  registered sum, (A + B + Cin) mod 2^DATA_WIDTH.
- CF  output  1  registered carry out of the MSB (unsigned overflow).
- OF  output  1  registered signed overflow.

## Operation
- Datapath: DATA_WIDTH full-adder cells, indexed i = 0..DATA_WIDTH-1.
  - Cell i computes s[i] = A[i] ^ B[i] ^ c[i].
  - Cell i computes c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i])).
  - c[0] = Cin.
- The carry ripples strictly from LSB to MSB.
  - No lookahead, select or bypass logic.
  - No behavioural "+" operator on the full-width operands. The chain is structural so that delay scales linearly with DATA_WIDTH.
- Flags:
  - CF = c[DATA_WIDTH].
  - OF = c[DATA_WIDTH] ^ c[DATA_WIDTH-1], i.e. carry into MSB XOR carry out of MSB.
  - Equivalent OF definition: A and B share a sign bit, and S has the opposite sign.
- Output register:
  - On every rising clk edge with rst_n high, S, CF and OF load the combinational result of the A, B and Cin values present before the edge.
  - No enable; the register updates every cycle.
- Reset:
  - rst_n low forces S = 0, CF = 0 and OF = 0 immediately, independent of clk.
  - The outputs hold these values while rst_n stays low.
- Arithmetic is modulo 2^DATA_WIDTH.
  - CF is the only indication of unsigned wrap.
  - OF is the only indication of signed wrap.
  - Both flags can be 1 in the same result.
- Cin participates in both flags exactly like any other carry. Example: A = 0x7FFF, B = 0, Cin = 1 gives OF = 1.

## Timing
- Latency: 1 clock cycle. Inputs sampled at edge N appear on S, CF and OF after edge N.
- Throughput: one addition per cycle. Back-to-back operand changes each cycle are legal.
- Critical path: Cin or A[0]/B[0] → carry chain → c[DATA_WIDTH] → OF/CF register D inputs.
  - The clock period must exceed the full ripple delay plus register setup.
  - Inputs are held stable from launch until the capturing edge; the block adds no input registers.
- Reset assertion mid-operation clears the outputs asynchronously. The in-flight result is discarded.
- Reset release: the first edge with rst_n high captures the then-current inputs. Deassertion is expected synchronous to clk.
- Outputs are glitch-free (direct register outputs). The internal ripple may glitch before settling.

## Test plan
- Reset: drive rst_n = 0 mid-cycle with nonzero outputs → S = 0x0000, CF = 0, OF = 0 immediately, with no clock edge. They stay 0 until release.
- Unsigned wrap: A = 0xFFFF, B = 0x0001, Cin = 0 → after one edge S = 0x0000, CF = 1, OF = 0.
- Signed positive overflow: A = 0x7FFF, B = 0x0001, Cin = 0 → S = 0x8000, CF = 0, OF = 1.
- Both flags: A = 0x8000, B = 0x8000, Cin = 0 → S = 0x0000, CF = 1, OF = 1.
- Carry-in through the full chain: A = 0xFFFF, B = 0x0000, Cin = 1 → S = 0x0000, CF = 1, OF = 0. A separate case A = 0x1234, B = 0x4321, Cin = 1 → S = 0x5556, CF = 0, OF = 0.
- Sweep with Cin = 0: 65,536 (A, B) pairs, one per cycle.
  - Compare S against (A + B) mod 2^16.
  - Compare CF against bit 16 of the 17-bit sum.
  - Compare OF against the signed-overflow rule.
  - Check for one-cycle latency and zero mismatches.

Source files
------------

// File: rtl/ripple_carry_adder_sync.sv
// ripple_carry_adder_sync: registered DATA_WIDTH-bit ripple-carry adder with sum, carry-out and signed-overflow flags
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset, clears S/CF/OF
//   A, B  - addends (unsigned or two's complement)
//   Cin   - carry into bit 0
//   S     - registered sum, (A + B + Cin) mod 2^DATA_WIDTH
//   CF    - registered carry out of the MSB
//   OF    - registered signed overflow
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

module ripple_carry_adder_sync #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  Cin,
  output logic [DATA_WIDTH-1:0] S,
  output logic                  CF,
  output logic                  OF
);
  logic [DATA_WIDTH:0]   c;
  logic [DATA_WIDTH-1:0] s;
  assign c[0] = Cin;
  // Structural chain so carry delay grows linearly with width
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_cell
    full_adder_cell u_fa (
      .a (A[i]),
      .b (B[i]),
      .ci(c[i]),
      .s (s[i]),
      .co(c[i+1])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S  <= '0;
      CF <= 1'b0;
      OF <= 1'b0;
    end else begin
      S  <= s;
      CF <= c[DATA_WIDTH];
      OF <= c[DATA_WIDTH] ^ c[DATA_WIDTH-1];
    end
  end
endmodule

// File: tb/tb_ripple_carry_adder_sync.sv
// tb_ripple_carry_adder_sync: directed and sweep checks of the registered ripple-carry adder
module tb_ripple_carry_adder_sync;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic [15:0] s;
  logic        cf;
  logic        of;
  int          total = 0;
  int          passed = 0;
  ripple_carry_adder_sync #(.DATA_WIDTH(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (a),
    .B    (b),
    .Cin  (cin),
    .S    (s),
    .CF   (cf),
    .OF   (of)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] es, input logic ecf, input logic eof);
    total++;
    assert ({s, cf, of} === {es, ecf, eof}) passed++;
    else $error("FAIL %s observed S=%h CF=%b OF=%b expected S=%h CF=%b OF=%b", tag, s, cf, of, es, ecf, eof);
  endtask
  task automatic step(input logic [15:0] na, input logic [15:0] nb, input logic nc);
    a = na;
    b = nb;
    cin = nc;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [16:0] sum;
    logic        ovf;
    #3;
    chk("reset_initial", 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("reset_held", 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(16'hFFFF, 16'h0001, 1'b0);
    chk("unsigned_wrap", 16'h0000, 1'b1, 1'b0);
    step(16'h7FFF, 16'h0001, 1'b0);
    chk("pos_overflow", 16'h8000, 1'b0, 1'b1);
    step(16'h8000, 16'h8000, 1'b0);
    chk("both_flags", 16'h0000, 1'b1, 1'b1);
    step(16'hFFFF, 16'h0000, 1'b1);
    chk("cin_full_chain", 16'h0000, 1'b1, 1'b0);
    step(16'h7FFF, 16'h0000, 1'b1);
    chk("cin_overflow", 16'h8000, 1'b0, 1'b1);
    step(16'h8000, 16'hFFFF, 1'b0);
    chk("neg_overflow", 16'h7FFF, 1'b1, 1'b1);
    step(16'hFFFF, 16'hFFFF, 1'b1);
    chk("all_ones_cin", 16'hFFFF, 1'b1, 1'b0);
    a = 16'h1234;
    b = 16'h4321;
    cin = 1'b1;
    #2;
    chk("latency_hold", 16'hFFFF, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("cin_plain", 16'h5556, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_async", 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("reset_stays", 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(16'h0001, 16'h0002, 1'b0);
    chk("after_release", 16'h0003, 1'b0, 1'b0);
    for (int k = 0; k < 65536; k++) begin
      logic [15:0] ka;
      logic [15:0] kb;
      ka = k[15:0];
      kb = {k[7:0], k[15:8]} ^ 16'h5A5A;
      step(ka, kb, 1'b0);
      sum = {1'b0, ka} + {1'b0, kb};
      ovf = (ka[15] == kb[15]) && (sum[15] != ka[15]);
      chk("sweep", sum[15:0], sum[16], ovf);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
